// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multicycle control sequencer for the MIPS-subset core. The datapath shares
//   one memory port and one ALU across cycles. This block walks each
//   instruction through its cycles and drives the datapath enables/selects
//   for the current cycle.
//
//   Outputs are Moore-style, decoded from the current state. The FETCH write
//   strobes, and the stalls in MEMRD/MEMWR, are additionally gated by the
//   memory handshake. The outputs are decoded combinationally so that an
//   asynchronous reset removes any in-flight strobe in the same cycle.
//
// Ports
//   clk            in   rising-edge system clock
//   reset_n        in   asynchronous active-low reset
//   op[5:0]        in   opcode from the instruction register (stable from DECODE)
//   mem_ready      in   memory access completes this cycle
//   pcwrite        out  unconditional PC write
//   branch         out  BEQ conditional PC write enable (taken if zero)
//   ble            out  BLE conditional PC write enable (taken if result <= 0)
//   iord           out  memory address select: 0=PC, 1=ALUOut
//   memwrite       out  memory write strobe
//   byte_enable    out  byte-wide store (SB)
//   irwrite        out  instruction register load
//   regwrite       out  register file write
//   regdst         out  destination select: 1=rd, 0=rt
//   memtoreg       out  write back from the memory data register
//   res_zeroextimm out  write back the zero-extended immediate (LI)
//   alusrca        out  ALU A: 0=PC, 1=rs
//   alusrcb[1:0]   out  ALU B: 00=rt, 01=4, 10=signimm, 11=signimm<<2
//   aluop[1:0]     out  00=add, 01=sub, 10=funct, 11=sub (BLE compare)
//   pcsrc[1:0]     out  00=ALU result, 01=ALUOut, 10=jump target
//   halted         out  sticky halt indicator
//   state[3:0]     out  current state encoding (debug)
//   instr_count    out  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             branch,
  output logic             ble,
  output logic             iord,
  output logic             memwrite,
  output logic             byte_enable,
  output logic             irwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             res_zeroextimm,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_LIWB     = 4'd12,
    S_HALT     = 4'd13,
    S_UNUSED14 = 4'd14,
    S_UNUSED15 = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LI    = 6'b010001;

  state_t           state_r;
  state_t           next_state_s;
  logic             retire_s;
  logic [CNT_W-1:0] instr_count_r;

  assign state       = state_r;
  assign instr_count = instr_count_r;

  // State register; reset lands in FETCH so fetch outputs apply during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter: bumps on each return to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count_r <= '0;
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  // Next-state and per-state datapath controls, all defaulted to idle first.
  always_comb begin
    next_state_s   = state_r;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    ble            = 1'b0;
    iord           = 1'b0;
    memwrite       = 1'b0;
    byte_enable    = 1'b0;
    irwrite        = 1'b0;
    regwrite       = 1'b0;
    regdst         = 1'b0;
    memtoreg       = 1'b0;
    res_zeroextimm = 1'b0;
    alusrca        = 1'b0;
    alusrcb        = 2'b00;
    aluop          = 2'b00;
    pcsrc          = 2'b00;
    halted         = 1'b0;

    case (state_r)
      S_FETCH: begin
        // PC+4 and IR load only commit when the instruction word arrives.
        alusrcb = 2'b01;
        pcwrite = mem_ready;
        irwrite = mem_ready;
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch target in ALUOut while decoding.
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:           next_state_s = S_EXECUTE;
          OP_LW, OP_SW, OP_SB: next_state_s = S_MEMADR;
          OP_BEQ, OP_BLE:     next_state_s = S_BRANCH;
          OP_ADDI:            next_state_s = S_ADDIEX;
          OP_J:               next_state_s = S_JUMP;
          OP_LI:              next_state_s = S_LIWB;
          default:            next_state_s = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW) begin
          next_state_s = S_MEMRD;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe is held for the whole stall until memory accepts it.
        iord        = 1'b1;
        memwrite    = 1'b1;
        byte_enable = (op == OP_SB);
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        alusrca      = 1'b1;
        aluop        = 2'b10;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        if (op == OP_BLE) begin
          aluop = 2'b11;
          ble   = 1'b1;
        end else begin
          aluop  = 2'b01;
          branch = 1'b1;
        end
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pcsrc        = 2'b10;
        pcwrite      = 1'b1;
        next_state_s = S_FETCH;
      end
      S_LIWB: begin
        regwrite       = 1'b1;
        res_zeroextimm = 1'b1;
        next_state_s   = S_FETCH;
      end
      S_HALT: begin
        halted       = 1'b1;
        next_state_s = S_HALT;
      end
      default: begin
        // Encodings 14/15 are unreachable; park safely if ever seen.
        next_state_s = S_HALT;
      end
    endcase

    if ((next_state_s == S_FETCH) && (state_r != S_FETCH)) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Directed bench for mc_ctrl_fsm. A behavioural model follows each
//   instruction as a short recipe of phases, chosen by opcode at decode time.
//   Handshake phases stall while mem_ready is low, and the instruction retires
//   when its recipe runs out. A compare process checks every DUT output against
//   the model on each falling edge. Hand-computed state sequences and counts
//   pin the model to the expected behaviour.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;
  localparam int CNT_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_STOP  = 6'b111111;
  localparam logic [5:0] OP_BAD   = 6'b000001;

  localparam logic [3:0] P_FETCH = 4'd0,  P_DECODE = 4'd1,  P_MEMADR = 4'd2;
  localparam logic [3:0] P_MEMRD = 4'd3,  P_MEMWB  = 4'd4,  P_MEMWR  = 4'd5;
  localparam logic [3:0] P_EXEC  = 4'd6,  P_ALUWB  = 4'd7,  P_BRANCH = 4'd8;
  localparam logic [3:0] P_ADDIEX = 4'd9, P_ADDIWB = 4'd10, P_JUMP   = 4'd11;
  localparam logic [3:0] P_LIWB  = 4'd12, P_HALT   = 4'd13;

  logic clk, reset_n, mem_ready;
  logic [5:0] op;
  logic pcwrite, branch, ble, iord, memwrite, byte_enable, irwrite, regwrite;
  logic regdst, memtoreg, res_zeroextimm, alusrca, halted;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;

  int n_cmp, n_bad;
  bit cmp_en;
  logic [3:0] state_log [$];
  int cnt_regwrite, cnt_regdst, cnt_memtoreg, cnt_memwrite, cnt_byte, cnt_halted;

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .ble(ble), .iord(iord),
    .memwrite(memwrite), .byte_enable(byte_enable), .irwrite(irwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .res_zeroextimm(res_zeroextimm), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Phases after DECODE: [13:12]=count, [3:0] first, [7:4] second, [11:8] third.
  function automatic logic [13:0] recipe(input logic [5:0] o);
    case (o)
      OP_RTYPE:       return {2'd2, 4'd0, P_ALUWB, P_EXEC};
      OP_LW:          return {2'd3, P_MEMWB, P_MEMRD, P_MEMADR};
      OP_SW, OP_SB:   return {2'd2, 4'd0, P_MEMWR, P_MEMADR};
      OP_BEQ, OP_BLE: return {2'd1, 8'd0, P_BRANCH};
      OP_ADDI:        return {2'd2, 4'd0, P_ADDIWB, P_ADDIEX};
      OP_J:           return {2'd1, 8'd0, P_JUMP};
      OP_LI:          return {2'd1, 8'd0, P_LIWB};
      default:        return {2'd1, 8'd0, P_HALT};
    endcase
  endfunction

  typedef struct packed {
    logic pcwrite, branch, ble, iord, memwrite, byte_enable, irwrite, regwrite;
    logic regdst, memtoreg, res_zeroextimm, alusrca, halted;
    logic [1:0] alusrcb, aluop, pcsrc;
  } outs_t;

  // What each phase must drive, straight from the per-state control table.
  function automatic outs_t expect_outs(input logic [3:0] ph, input logic [5:0] o, input logic mr);
    outs_t e;
    e = '0;
    case (ph)
      P_FETCH:  begin e.alusrcb = 2'b01; e.pcwrite = mr; e.irwrite = mr; end
      P_DECODE: e.alusrcb = 2'b11;
      P_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      P_MEMRD:  e.iord = 1'b1;
      P_MEMWB:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      P_MEMWR:  begin e.iord = 1'b1; e.memwrite = 1'b1; e.byte_enable = (o == OP_SB); end
      P_EXEC:   begin e.alusrca = 1'b1; e.aluop = 2'b10; end
      P_ALUWB:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      P_BRANCH: begin
        e.alusrca = 1'b1; e.pcsrc = 2'b01;
        if (o == OP_BLE) begin e.aluop = 2'b11; e.ble = 1'b1; end
        else begin e.aluop = 2'b01; e.branch = 1'b1; end
      end
      P_ADDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      P_ADDIWB: e.regwrite = 1'b1;
      P_JUMP:   begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      P_LIWB:   begin e.regwrite = 1'b1; e.res_zeroextimm = 1'b1; end
      P_HALT:   e.halted = 1'b1;
      default:  e = '0;
    endcase
    return e;
  endfunction

  // Model: current phase, remaining recipe phases, retired count.
  logic [13:0] rec_s;
  logic [3:0] m_ph;
  logic [7:0] m_rest;
  int m_left;
  logic [CNT_W-1:0] m_cnt;
  assign rec_s = recipe(op);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= P_FETCH; m_rest <= '0; m_left <= 0; m_cnt <= '0;
    end else if (m_ph == P_HALT) begin
      m_ph <= P_HALT;
    end else if ((m_ph == P_FETCH || m_ph == P_MEMRD || m_ph == P_MEMWR) && !mem_ready) begin
      m_ph <= m_ph;
    end else if (m_ph == P_FETCH) begin
      m_ph <= P_DECODE;
    end else if (m_ph == P_DECODE) begin
      m_ph <= rec_s[3:0]; m_rest <= rec_s[11:4]; m_left <= int'(rec_s[13:12]) - 1;
    end else if (m_left == 0) begin
      m_ph <= P_FETCH; m_cnt <= m_cnt + 32'd1;
    end else begin
      m_ph <= m_rest[3:0]; m_rest <= {4'd0, m_rest[7:4]}; m_left <= m_left - 1;
    end
  end

  // Compare process: every falling edge, DUT vs model, plus activity logs.
  outs_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e = expect_outs(m_ph, op, mem_ready);
        chk("state", 32'(state), 32'(m_ph));
        chk("instr_count", instr_count, m_cnt);
        chk("pcwrite", 32'(pcwrite), 32'(e.pcwrite));
        chk("branch", 32'(branch), 32'(e.branch));
        chk("ble", 32'(ble), 32'(e.ble));
        chk("iord", 32'(iord), 32'(e.iord));
        chk("memwrite", 32'(memwrite), 32'(e.memwrite));
        chk("byte_enable", 32'(byte_enable), 32'(e.byte_enable));
        chk("irwrite", 32'(irwrite), 32'(e.irwrite));
        chk("regwrite", 32'(regwrite), 32'(e.regwrite));
        chk("regdst", 32'(regdst), 32'(e.regdst));
        chk("memtoreg", 32'(memtoreg), 32'(e.memtoreg));
        chk("res_zeroextimm", 32'(res_zeroextimm), 32'(e.res_zeroextimm));
        chk("alusrca", 32'(alusrca), 32'(e.alusrca));
        chk("alusrcb", 32'(alusrcb), 32'(e.alusrcb));
        chk("aluop", 32'(aluop), 32'(e.aluop));
        chk("pcsrc", 32'(pcsrc), 32'(e.pcsrc));
        chk("halted", 32'(halted), 32'(e.halted));
        state_log.push_back(state);
        cnt_regwrite += int'(regwrite);
        cnt_regdst   += int'(regdst);
        cnt_memtoreg += int'(memtoreg);
        cnt_memwrite += int'(memwrite);
        cnt_byte     += int'(byte_enable);
        cnt_halted   += int'(halted);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    state_log.delete();
    cnt_regwrite = 0; cnt_regdst = 0; cnt_memtoreg = 0;
    cnt_memwrite = 0; cnt_byte = 0; cnt_halted = 0;
  endtask

  // Compare logged states with a literal list (nibble 0 = first cycle).
  task automatic check_log(input string name, input int n, input logic [31:0] seq);
    chk({name, "_len"}, 32'(state_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < state_log.size()) chk({name, "_state"}, 32'(state_log[i]), 32'(seq[4*i +: 4]));
    end
  endtask

  // Run one instruction with mem_ready high, then park in FETCH.
  task automatic simple_instr(input logic [5:0] o, input int n, input logic [31:0] seq, input string name);
    clear_logs();
    op = o; mem_ready = 1'b1;
    run(n);
    mem_ready = 1'b0;
    run(1);
    check_log(name, n + 1, seq);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cmp_en = 1'b0;
    clear_logs();
    reset_n = 1'b1; mem_ready = 1'b1; op = OP_RTYPE;
    #1 reset_n = 1'b0; cmp_en = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_fetch_pcwrite", 32'(pcwrite), 32'd1);
    chk("rst_fetch_irwrite", 32'(irwrite), 32'd1);
    chk("rst_fetch_alusrcb", 32'(alusrcb), 32'd1);
    mem_ready = 1'b0;
    #1 chk("rst_pcwrite_gated", 32'(pcwrite), 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // RTYPE: 4 cycles
    simple_instr(OP_RTYPE, 4, 32'h0007_6100 >> 4 | 32'h0, "rtype");
    chk("rtype_regwrite_once", 32'(cnt_regwrite), 32'd1);
    chk("rtype_regdst_once", 32'(cnt_regdst), 32'd1);
    chk("rtype_count", instr_count, 32'd1);

    // LW with two MEMRD stall cycles
    clear_logs();
    op = OP_LW; mem_ready = 1'b1;
    run(3); mem_ready = 1'b0;
    run(2); mem_ready = 1'b1;
    run(1); mem_ready = 1'b0;
    run(2);
    check_log("lw", 8, 32'h0433_3210);
    chk("lw_memtoreg_once", 32'(cnt_memtoreg), 32'd1);
    chk("lw_regwrite_once", 32'(cnt_regwrite), 32'd1);
    chk("lw_count", instr_count, 32'd2);

    // SB with one MEMWR stall cycle
    clear_logs();
    op = OP_SB; mem_ready = 1'b1;
    run(3); mem_ready = 1'b0;
    run(1); mem_ready = 1'b1;
    run(1); mem_ready = 1'b0;
    run(1);
    check_log("sb", 6, 32'h0005_5210);
    chk("sb_memwrite_cycles", 32'(cnt_memwrite), 32'd2);
    chk("sb_byte_cycles", 32'(cnt_byte), 32'd2);
    chk("sb_no_regwrite", 32'(cnt_regwrite), 32'd0);
    chk("sb_count", instr_count, 32'd3);

    // BLE then BEQ back to back
    clear_logs();
    op = OP_BLE; mem_ready = 1'b1;
    run(2);
    chk("ble_en", 32'(ble), 32'd1);
    chk("ble_aluop", 32'(aluop), 32'd3);
    chk("ble_pcsrc", 32'(pcsrc), 32'd1);
    chk("ble_no_branch", 32'(branch), 32'd0);
    run(1); op = OP_BEQ;
    run(2);
    chk("beq_en", 32'(branch), 32'd1);
    chk("beq_aluop", 32'(aluop), 32'd1);
    chk("beq_pcsrc", 32'(pcsrc), 32'd1);
    chk("beq_no_ble", 32'(ble), 32'd0);
    run(1); mem_ready = 1'b0;
    run(1);
    chk("branch_count", instr_count, 32'd5);

    // ADDI (4 cycles), J and LI (3 cycles)
    simple_instr(OP_ADDI, 4, 32'h0000_A910, "addi");
    simple_instr(OP_J, 3, 32'h0000_0B10, "j");
    simple_instr(OP_LI, 3, 32'h0000_0C10, "li");
    chk("after_li_count", instr_count, 32'd8);

    // Stop opcode: HALT is absorbing, count frozen
    clear_logs();
    op = OP_STOP; mem_ready = 1'b1;
    run(2);
    chk("halt_state", 32'(state), 32'd13);
    chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'(i % 2);
      run(1);
    end
    chk("halt_cycles", 32'(cnt_halted), 32'd20);
    chk("halt_frozen_count", instr_count, 32'd8);
    chk("halt_still", 32'(state), 32'd13);
    reset_n = 1'b0; mem_ready = 1'b0;
    #1;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_count", instr_count, 32'd0);
    chk("halt_rst_flag", 32'(halted), 32'd0);
    run(1); reset_n = 1'b1;

    // Illegal opcode also halts
    clear_logs();
    op = OP_BAD; mem_ready = 1'b1;
    run(2);
    chk("illegal_state", 32'(state), 32'd13);
    chk("illegal_halted", 32'(halted), 32'd1);
    reset_n = 1'b0; mem_ready = 1'b0;
    run(1); reset_n = 1'b1;

    // Reset in the middle of a stalled store
    simple_instr(OP_J, 3, 32'h0000_0B10, "j2");
    chk("j2_count", instr_count, 32'd1);
    clear_logs();
    op = OP_SW; mem_ready = 1'b1;
    run(3); mem_ready = 1'b0;
    run(1);
    chk("sw_memwrite_held", 32'(memwrite), 32'd1);
    chk("sw_byte_off", 32'(byte_enable), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("sw_rst_memwrite_drop", 32'(memwrite), 32'd0);
    chk("sw_rst_state", 32'(state), 32'd0);
    chk("sw_rst_count", instr_count, 32'd0);
    run(1); reset_n = 1'b1;
    run(1);
    chk("sw_after_release_state", 32'(state), 32'd0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
